load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage of the rv32i_sc core, directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs one word-wide data-memory transaction over a req/ack bus: byte-lane steering, write strobes, load sign/zero extension.
- Returns load data or a fault code to writeback, with a done pulse.

Parameters:
- XLEN, 32, data/address width (equals `INSTR_WIDTH).
- TIMEOUT_CYCLES, 16, max cycles mem_req may stay high without mem_ack before a bus fault.
- TO_W, 5, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  memory-op request from the execute stage.
- req_ready  out  1  unit can accept a request (IDLE only).
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  XLEN  effective address (ALU results).
- store_data  in  XLEN  rs2 value.
- done  out  1  one-cycle completion pulse.
- load_data  out  XLEN  extended load result; valid while done=1.
- fault  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3; valid while done=1.
- mem_req  out  1  bus request, held until ack or timeout.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  word address: addr with bits [1:0] forced to 0.
- mem_wstrb  out  4  byte-lane write strobes.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_ack  in  1  bus completion, single-cycle pulse.
- mem_rdata  in  XLEN  read word, valid with mem_ack.

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=1; done=0; fault=00; load_data=0; mem_req=0; mem_we=0; mem_addr=0; mem_wstrb=0; mem_wdata=0; timeout counter=0.
- Reset during BUS aborts the transaction: mem_req drops immediately and no done is produced.
- Accept: a request is accepted on a clk edge with req_valid=1 in IDLE. Inputs are sampled only at accept and registered.
- Checks at accept, in priority order:
  - Illegal funct3: loads allow 011, 110, 111 as illegal; stores allow only 000/001/010. Result: fault=11.
  - Misaligned: H with addr[0]=1, or W with addr[1:0]!=0. Result: fault=01.
- Faulting request: goes to RESP with no bus activity (mem_req stays 0).
- Legal request goes to BUS. Registered outputs for BUS:
  - mem_req=1; mem_we=is_store; mem_addr={addr[31:2],2'b00}.
  - Stores: B → wstrb=0001<<addr[1:0], wdata={4{sd[7:0]}}. H → wstrb=0011<<addr[1:0], wdata={2{sd[15:0]}}. W → wstrb=1111, wdata=sd.
  - Loads: wstrb=0000.
- BUS state:
  - Counter increments each cycle mem_req=1.
  - On mem_ack: capture mem_rdata; go to RESP with fault=00.
  - If the counter reaches TIMEOUT_CYCLES with no ack: go to RESP with fault=10, load_data=0.
  - Leaving BUS clears mem_req, mem_we, mem_wstrb and the counter.
- Ack and timeout on the same cycle: ack wins.
- Load extraction on ack, by byte offset o=addr[1:0]:
  - B: sign-extend rdata[8o+7:8o].
  - BU: zero-extend the same byte.
  - H: sign-extend rdata[8o+15:8o], o ∈ {0,2}.
  - HU: zero-extend the same halfword.
  - W: rdata unchanged.
  - Stores: load_data=0.
- RESP: done=1 for exactly one cycle; load_data and fault held; next state IDLE. load_data/fault keep their values until the next done.
- Latency (accept edge = cycle 0):
  - mem_req first high in cycle 1.
  - ack in cycle k gives done in cycle k+1.
  - Fault-at-accept gives done in cycle 1.
  - Minimum legal op: 2 cycles.
- req_ready=0 in BUS and RESP; req_valid there is ignored, not queued.
- mem_ack outside BUS is ignored.

Decomposition:
- Add to rv32i_control.vh:
  - Width codes `LS_B, `LS_H, `LS_W, `LS_BU, `LS_HU.
  - Fault codes `LSU_OK, `LSU_MISALIGN, `LSU_BUSERR, `LSU_ILLEGAL.
  - FSM encodings `LSU_IDLE, `LSU_BUS, `LSU_RESP.
- Reuse `INSTR_WIDTH from rv32i_params.vh.
- Sub-module lsu_align (combinational):
  - Store path: strobe/wdata generation.
  - Load path: lane extraction and extension.
  - Alignment/illegal check.
  - Keeps the FSM top-level lean, and is unit-testable alone.

Test Plan:
- SB: addr=0x1003, sd=0xAABBCCDD, ack after 3 cycles → mem_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD, mem_we=1; done in cycle 4 with fault=00.
- LB then LBU at addr=0x2001, rdata=0x12F08034 → load_data=0xFFFFFF80, then 0x00000080.
- LH at addr=0x2002, rdata=0x8001_7FFF → 0xFFFF8001. LW at 0x2004 → rdata unchanged.
- LW at addr=0x2006 → no mem_req, done in cycle 1, fault=01. SH at 0x3001 → fault=01. Load with funct3=011 → fault=11.
- LW with mem_ack never asserted → mem_req high exactly 16 cycles, then done with fault=10, load_data=0. Repeat with ack on the 16th cycle → fault=00.
- Assert rst while in BUS:
  - mem_req=0 immediately; no done.
  - req_ready=1 after release.
  - A req_valid pulse during BUS is not accepted.
  - Back-to-back requests accepted only in IDLE.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg : width/fault codes, FSM states and funct3 legality
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package load_store_unit_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [1:0] LSU_OK       = 2'b00;
  localparam logic [1:0] LSU_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_BUSERR   = 2'b10;
  localparam logic [1:0] LSU_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      LS_B, LS_H, LS_W: ok = 1'b1;
      LS_BU, LS_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ---------------------------------------------------------------------------
// load_store_unit_align : byte-lane steering, load extension, access checks
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  output logic [1:0]      chk_fault,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  input  logic            ld_is_store,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    chk_fault = LSU_OK;
    if (!funct3_legal(is_store, funct3)) begin
      chk_fault = LSU_ILLEGAL;
    end else if ((funct3[1:0] == 2'b01 && addr_lo[0]) ||
                 (funct3[1:0] == 2'b10 && addr_lo != 2'b00)) begin
      chk_fault = LSU_MISALIGN;
    end
  end

  always_comb begin
    wstrb = 4'b0000;
    wdata = '0;
    if (is_store) begin
      case (funct3)
        LS_B: begin
          wstrb = 4'b0001 << addr_lo;
          wdata = {(XLEN/8){store_data[7:0]}};
        end
        LS_H: begin
          wstrb = 4'b0011 << addr_lo;
          wdata = {(XLEN/16){store_data[15:0]}};
        end
        default: begin
          wstrb = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  // Aligned accesses guarantee the selected lane sits entirely in the word.
  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      LS_B:    ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LS_BU:   ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LS_H:    ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LS_HU:   ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
    if (ld_is_store) begin
      ld_data = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : memory stage, one req/ack data-bus transaction per op
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic [1:0]      fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e      state_q, state_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [1:0]      fault_q, fault_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            st_q, st_d;

  logic [1:0]      chk_fault;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] ld_data;
  logic [TO_W-1:0] cnt_inc;
  logic            leave_bus;

  load_store_unit_align #(.XLEN(XLEN)) u_lsu_align (
    .is_store    (is_store),
    .funct3      (funct3),
    .addr_lo     (addr[1:0]),
    .store_data  (store_data),
    .chk_fault   (chk_fault),
    .wstrb       (wstrb),
    .wdata       (wdata),
    .ld_is_store (st_q),
    .ld_funct3   (f3_q),
    .ld_off      (off_q),
    .rdata       (mem_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    load_data_d = load_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    st_d        = st_q;
    cnt_inc     = cnt_q + 1'b1;
    leave_bus   = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          f3_d    = funct3;
          off_d   = addr[1:0];
          st_d    = is_store;
          ready_d = 1'b0;
          if (chk_fault != LSU_OK) begin
            state_d     = LSU_RESP;
            done_d      = 1'b1;
            fault_d     = chk_fault;
            load_data_d = '0;
          end else begin
            state_d     = LSU_BUS;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[XLEN-1:2], 2'b00};
            mem_wstrb_d = wstrb;
            mem_wdata_d = wdata;
          end
        end
      end
      LSU_BUS: begin
        // An ack arriving on the timeout cycle still completes normally.
        if (mem_ack) begin
          leave_bus   = 1'b1;
          fault_d     = LSU_OK;
          load_data_d = ld_data;
        end else if (cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
          leave_bus   = 1'b1;
          fault_d     = LSU_BUSERR;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
        if (leave_bus) begin
          state_d     = LSU_RESP;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          cnt_d       = '0;
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = LSU_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      fault_q     <= LSU_OK;
      load_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      st_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      st_q        <= st_d;
    end
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed vector table plus multi-cycle corner sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ack;     // bus cycle carrying mem_ack, 0 = never
    logic [1:0]  fault;
    logic [31:0] ld;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int   done_cyc;
    int   req_cyc;
    int   exp_done;
    int   exp_req;
    logic seen;
    logic bus;
    bus = (v.fault == 2'b00) || (v.fault == 2'b10);
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), {31'd0, req_ready}, 32'd1);
    is_store   = v.st;
    funct3     = v.f3;
    addr       = v.addr;
    store_data = v.sd;
    mem_rdata  = v.rdata;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    done_cyc  = 0;
    req_cyc   = 0;
    seen      = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      mem_ack = 1'b0;
      if (done) begin
        done_cyc = c;
        chk($sformatf("v%0d fault", idx), {30'd0, fault}, {30'd0, v.fault});
        chk($sformatf("v%0d load_data", idx), load_data, v.ld);
        break;
      end
      if (mem_req) begin
        req_cyc++;
        if (!seen) begin
          seen = 1'b1;
          chk($sformatf("v%0d mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.st});
          chk($sformatf("v%0d mem_wstrb", idx), {28'd0, mem_wstrb}, {28'd0, v.wstrb});
          if (v.st) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        end
      end
      if (c == v.ack) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack  = 1'b0;
    exp_done = !bus ? 1 : (v.ack != 0 ? v.ack + 1 : 17);
    exp_req  = !bus ? 0 : (v.ack != 0 ? v.ack : 16);
    chk($sformatf("v%0d done_cycle", idx), done_cyc, exp_done);
    chk($sformatf("v%0d req_cycles", idx), req_cyc, exp_req);
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d ready_after", idx), {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int   seen_done;
    int   seen_req;
    logic exp_done_pat[4];
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;

    //              st    f3      addr          sd            rdata         ack fault  ld            wstrb    wdata
    vecs[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0,        3, 2'b00, 32'h0,        4'b1000, 32'hDDDD_DDDD};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_2001, 32'h0,        32'h12F0_8034, 1, 2'b00, 32'hFFFF_FF80, 4'b0000, 32'h0};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_2001, 32'h0,        32'h12F0_8034, 1, 2'b00, 32'h0000_0080, 4'b0000, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_7FFF, 2, 2'b00, 32'hFFFF_8001, 4'b0000, 32'h0};
    vecs[4]  = '{1'b0, 3'b010, 32'h0000_2004, 32'h0,        32'h8001_7FFF, 1, 2'b00, 32'h8001_7FFF, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, 3'b010, 32'h0000_2006, 32'h0,        32'h0,        1, 2'b01, 32'h0,        4'b0000, 32'h0};
    vecs[6]  = '{1'b1, 3'b001, 32'h0000_3001, 32'h1234_5678, 32'h0,        1, 2'b01, 32'h0,        4'b0000, 32'h0};
    vecs[7]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1, 2'b11, 32'h0,        4'b0000, 32'h0};
    vecs[8]  = '{1'b1, 3'b001, 32'h0000_3002, 32'h1122_3344, 32'h0,        2, 2'b00, 32'h0,        4'b1100, 32'h3344_3344};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,        1, 2'b00, 32'h0,        4'b1111, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 3'b101, 32'h0000_2000, 32'h0,        32'h12F0_8034, 1, 2'b00, 32'h0000_8034, 4'b0000, 32'h0};
    vecs[11] = '{1'b1, 3'b100, 32'h0000_0200, 32'h0,        32'h0,        1, 2'b11, 32'h0,        4'b0000, 32'h0};
    vecs[12] = '{1'b0, 3'b000, 32'h0000_2003, 32'h0,        32'h12F0_8034, 2, 2'b00, 32'h0000_0012, 4'b0000, 32'h0};
    vecs[13] = '{1'b0, 3'b010, 32'h0000_5000, 32'h0,        32'hDEAD_BEEF, 0, 2'b10, 32'h0,        4'b0000, 32'h0};
    vecs[14] = '{1'b0, 3'b010, 32'h0000_5000, 32'h0,        32'hDEAD_BEEF, 16, 2'b00, 32'hDEAD_BEEF, 4'b0000, 32'h0};

    #12;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst fault", {30'd0, fault}, 32'd0);
    chk("rst load_data", load_data, 32'd0);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i], i);
    end

    // Reset in the middle of a bus transaction.
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_6000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstbus mem_req_before", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstbus mem_req_now", {31'd0, mem_req}, 32'd0);
    chk("rstbus ready_now", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    seen_req  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) seen_done++;
      if (mem_req) seen_req++;
    end
    chk("rstbus no_done", seen_done, 0);
    chk("rstbus no_req", seen_req, 0);
    chk("rstbus ready_after", {31'd0, req_ready}, 32'd1);

    // Ack while idle is ignored.
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack done", {31'd0, done}, 32'd0);
    chk("idle_ack mem_req", {31'd0, mem_req}, 32'd0);

    // A request presented during BUS is neither accepted nor queued.
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_2004;
    mem_rdata = 32'h0BAD_F00D; req_valid = 1'b1;
    @(negedge clk);
    is_store = 1'b1; addr = 32'h0000_7000; store_data = 32'h5555_5555;
    @(negedge clk);
    chk("busreq ready", {31'd0, req_ready}, 32'd0);
    chk("busreq mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("busreq done", {31'd0, done}, 32'd1);
    chk("busreq load_data", load_data, 32'h0BAD_F00D);
    seen_done = 0;
    seen_req  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) seen_done++;
      if (mem_req) seen_req++;
    end
    chk("busreq no_done", seen_done, 0);
    chk("busreq no_req", seen_req, 0);

    // Held request: each accept happens only once the unit is back in IDLE.
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_2006; req_valid = 1'b1;
    exp_done_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("b2b done c%0d", c + 1), {31'd0, done}, {31'd0, exp_done_pat[c]});
      chk($sformatf("b2b ready c%0d", c + 1), {31'd0, req_ready}, {31'd0, ~exp_done_pat[c]});
    end
    req_valid = 1'b0;
    chk("b2b fault", {30'd0, fault}, 32'd1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
